// File: rtl/circ_buf_pkg.sv
// circ_buf_pkg: shared helpers for the circular-buffer FIFO.
//   addr_w        - storage index width for a given depth
//   is_pow2       - power-of-two test used by the elaboration checks
//   thresh_ok     - range check for the almost-full / almost-empty thresholds
//   flag_at_least - almost-full rule (count >= threshold)
//   flag_at_most  - almost-empty rule (count <= threshold)
package circ_buf_pkg;

  localparam int MIN_DEPTH = 2;

  function automatic int addr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  function automatic bit is_pow2(input int v);
    return (v > 0) && ((v & (v - 1)) == 0);
  endfunction

  function automatic bit thresh_ok(input int depth, input int af, input int ae);
    return (af >= 1) && (af <= depth) && (ae >= 0) && (ae <= depth - 1);
  endfunction

  function automatic logic flag_at_least(input int count, input int thresh);
    return count >= thresh;
  endfunction

  function automatic logic flag_at_most(input int count, input int thresh);
    return count <= thresh;
  endfunction

endpackage

// File: rtl/circ_buf_ram.sv
// circ_buf_ram: DEPTH x DATA_W storage for the FIFO.
//   clk   - write clock
//   we    - write enable (sampled on rising clk)
//   waddr - write index
//   wdata - write payload
//   raddr - read index (asynchronous read)
//   rdata - payload at raddr
// Contents are deliberately not reset.
module circ_buf_ram #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 8,
  parameter int ADDR_W = 3
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/circ_buf_fifo.sv
// circ_buf_fifo: parametrised circular-buffer FIFO, first-word fall-through.
//   clk            - clock, all state updates on the rising edge
//   arst           - asynchronous active-high reset
//   flush_i        - synchronous clear, highest priority
//   valid_i/data_i - producer side, ready_o - FIFO can accept
//   valid_o/data_o - consumer side, ready_i - consumer accepts
//   count_o        - occupancy 0..DEPTH
//   almost_full_o  - count >= AF_THRESH
//   almost_empty_o - count <= AE_THRESH
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high on that side. valid_o and ready_o come from registers only, so
// neither has a combinational path from ready_i or valid_i; once valid_o is
// high it stays high, with data_o stable, until the pop.
module circ_buf_fifo
  import circ_buf_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter int DEPTH     = 8,
  parameter int AF_THRESH = DEPTH - 1,
  parameter int AE_THRESH = 1
) (
  input  logic                     clk,
  input  logic                     arst,
  input  logic                     flush_i,
  input  logic                     valid_i,
  input  logic [DATA_W-1:0]        data_i,
  output logic                     ready_o,
  output logic                     valid_o,
  output logic [DATA_W-1:0]        data_o,
  input  logic                     ready_i,
  output logic [addr_w(DEPTH):0]   count_o,
  output logic                     almost_full_o,
  output logic                     almost_empty_o
);

  localparam int ADDR_W = addr_w(DEPTH);
  localparam int CNT_W  = ADDR_W + 1;
  localparam logic [ADDR_W:0]  PTR_ONE = 1;
  localparam logic [CNT_W-1:0] CNT_ONE = 1;

  if (!is_pow2(DEPTH) || DEPTH < MIN_DEPTH) begin : g_bad_depth
    $error("circ_buf_fifo: DEPTH must be a power of two and at least 2");
  end
  if (!thresh_ok(DEPTH, AF_THRESH, AE_THRESH)) begin : g_bad_thresh
    $error("circ_buf_fifo: AF_THRESH or AE_THRESH out of range");
  end
  if (DATA_W < 1) begin : g_bad_width
    $error("circ_buf_fifo: DATA_W must be at least 1");
  end

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  logic [ADDR_W:0]  wr_ptr_q, wr_ptr_d;
  logic [ADDR_W:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             ready_q, ready_d;
  logic             empty, push, pop, full_d;

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign push  = valid_i & ready_q;
  assign pop   = ~empty & ready_i;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      // Flush drops any push or pop presented in the same cycle.
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PTR_ONE;
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
      case ({push, pop})
        2'b10:   count_d = count_q + CNT_ONE;
        2'b01:   count_d = count_q - CNT_ONE;
        default: count_d = count_q;
      endcase
    end
    // ready is registered from the next-state fullness: a pop while full
    // frees a slot only from the following cycle, giving one bubble.
    full_d  = (wr_ptr_d[ADDR_W] != rd_ptr_d[ADDR_W]) &&
              (wr_ptr_d[ADDR_W-1:0] == rd_ptr_d[ADDR_W-1:0]);
    ready_d = ~full_d;
  end

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ready_q  <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ready_q  <= ready_d;
    end
  end

  circ_buf_ram #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk   (clk),
    .we    (push & ~flush_i),
    .waddr (wr_ptr_q[ADDR_W-1:0]),
    .wdata (data_i),
    .raddr (rd_ptr_q[ADDR_W-1:0]),
    .rdata (data_o)
  );

  assign ready_o        = ready_q;
  assign valid_o        = ~empty;
  assign count_o        = count_q;
  assign almost_full_o  = flag_at_least(int'(count_q), AF_THRESH);
  assign almost_empty_o = flag_at_most(int'(count_q), AE_THRESH);

  // Write pointer may only move on an accepted push (or flush).
  a_no_push_when_not_ready: assert property (
    @(posedge clk) disable iff (arst)
    (!ready_q && !flush_i) |=> (wr_ptr_q == $past(wr_ptr_q)));

  // Read pointer may only move on a pop of valid data (or flush).
  a_no_pop_when_empty: assert property (
    @(posedge clk) disable iff (arst)
    (empty && !flush_i) |=> (rd_ptr_q == $past(rd_ptr_q)));

  a_count_in_range: assert property (
    @(posedge clk) disable iff (arst)
    count_q <= CNT_W'(DEPTH));

endmodule

// File: tb/tb_circ_buf_fifo.sv
// tb_circ_buf_fifo: self-checking bench for circ_buf_fifo (DEPTH=8, DATA_W=8).
// The reference is a plain queue of stored words plus a "ready" bit that
// follows the rule: ready is low in reset and otherwise reflects whether the
// queue had room after the last edge.
module tb_circ_buf_fifo;

  localparam int DATA_W    = 8;
  localparam int DEPTH     = 8;
  localparam int AF_THRESH = 7;
  localparam int AE_THRESH = 1;
  localparam int CNT_W     = 4;

  logic              clk = 1'b0;
  logic              arst;
  logic              flush_i;
  logic              valid_i;
  logic [DATA_W-1:0] data_i;
  logic              ready_o;
  logic              valid_o;
  logic [DATA_W-1:0] data_o;
  logic              ready_i;
  logic [CNT_W-1:0]  count_o;
  logic              almost_full_o;
  logic              almost_empty_o;

  int checks   = 0;
  int failures = 0;

  logic [DATA_W-1:0] model_q[$];
  logic [DATA_W-1:0] exp_q[$];
  logic [DATA_W-1:0] obs_q[$];
  bit                mdl_ready;

  // Clock / reset block
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  circ_buf_fifo #(
    .DATA_W    (DATA_W),
    .DEPTH     (DEPTH),
    .AF_THRESH (AF_THRESH),
    .AE_THRESH (AE_THRESH)
  ) dut (
    .clk            (clk),
    .arst           (arst),
    .flush_i        (flush_i),
    .valid_i        (valid_i),
    .data_i         (data_i),
    .ready_o        (ready_o),
    .valid_o        (valid_o),
    .data_o         (data_o),
    .ready_i        (ready_i),
    .count_o        (count_o),
    .almost_full_o  (almost_full_o),
    .almost_empty_o (almost_empty_o)
  );

  // Driver: called 2 time units after a rising edge; applies inputs for one
  // cycle, updates the reference and returns 2 units after the next edge.
  task automatic drive_cycle(input logic v, input logic [DATA_W-1:0] d,
                             input logic r, input logic fl);
    bit do_push;
    bit do_pop;
    valid_i = v;
    data_i  = d;
    ready_i = r;
    flush_i = fl;
    do_pop  = r && (model_q.size() != 0) && !fl;
    do_push = v && mdl_ready && !fl;
    if (do_pop) begin
      exp_q.push_back(model_q.pop_front());
      obs_q.push_back(data_o);
    end
    if (do_push) model_q.push_back(d);
    if (fl) model_q.delete();
    @(posedge clk);
    #2;
    mdl_ready = (model_q.size() < DEPTH);
  endtask

  task automatic test_reset();
    arst = 1'b1; flush_i = 1'b0; valid_i = 1'b0; ready_i = 1'b0; data_i = '0;
    model_q.delete(); mdl_ready = 1'b0;
    repeat (5) begin
      @(posedge clk);
      #2;
      checks++;
      if (ready_o !== 1'b0) begin failures++; $display("FAIL reset_ready got=%b exp=0", ready_o); end
    end
    checks++;
    if (valid_o !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", valid_o); end
    checks++;
    if (count_o !== '0) begin failures++; $display("FAIL reset_count got=%0d exp=0", count_o); end
    checks++;
    if (almost_empty_o !== 1'b1) begin failures++; $display("FAIL reset_ae got=%b exp=1", almost_empty_o); end
    checks++;
    if (almost_full_o !== 1'b0) begin failures++; $display("FAIL reset_af got=%b exp=0", almost_full_o); end
    arst = 1'b0;
    #1;
    checks++;
    if (ready_o !== 1'b0) begin failures++; $display("FAIL release_ready_pre_edge got=%b exp=0", ready_o); end
    #1;
    drive_cycle(1'b0, '0, 1'b0, 1'b0);
    checks++;
    if (ready_o !== 1'b1) begin failures++; $display("FAIL release_ready got=%b exp=1", ready_o); end
    checks++;
    if (valid_o !== 1'b0 || count_o !== '0) begin
      failures++; $display("FAIL idle_state got valid=%b count=%0d exp valid=0 count=0", valid_o, count_o);
    end
  endtask

  task automatic test_fill_drain();
    logic exp_af, exp_ae;
    for (int k = 1; k <= DEPTH; k++) begin
      drive_cycle(1'b1, DATA_W'(k), 1'b0, 1'b0);
      exp_af = (k >= AF_THRESH);
      exp_ae = (k <= AE_THRESH);
      checks++;
      if (count_o !== CNT_W'(k)) begin failures++; $display("FAIL fill_count got=%0d exp=%0d", count_o, k); end
      checks++;
      if (almost_full_o !== exp_af) begin failures++; $display("FAIL fill_af got=%b exp=%b at %0d", almost_full_o, exp_af, k); end
      checks++;
      if (almost_empty_o !== exp_ae) begin failures++; $display("FAIL fill_ae got=%b exp=%b at %0d", almost_empty_o, exp_ae, k); end
    end
    checks++;
    if (ready_o !== 1'b0) begin failures++; $display("FAIL full_ready got=%b exp=0", ready_o); end
    for (int k = 0; k < DEPTH; k++) drive_cycle(1'b0, '0, 1'b1, 1'b0);
    checks++;
    if (valid_o !== 1'b0) begin failures++; $display("FAIL drain_valid got=%b exp=0", valid_o); end
    checks++;
    if (obs_q.size() != DEPTH) begin failures++; $display("FAIL drain_len got=%0d exp=%0d", obs_q.size(), DEPTH); end
    for (int i = 0; i < obs_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== DATA_W'(i + 1)) begin failures++; $display("FAIL drain_data[%0d] got=%0h exp=%0h", i, obs_q[i], i + 1); end
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_wrap();
    int pushed;
    int cyc;
    bit acc;
    pushed = 0;
    cyc = 0;
    while (pushed < 20 && cyc < 100) begin
      acc = mdl_ready;
      drive_cycle(1'b1, DATA_W'($urandom_range(0, 255)), cyc[0], 1'b0);
      if (acc) pushed++;
      cyc++;
      checks++;
      if (count_o !== CNT_W'(model_q.size())) begin failures++; $display("FAIL wrap_count got=%0d exp=%0d", count_o, model_q.size()); end
    end
    for (int k = 0; k < 2 * DEPTH && model_q.size() != 0; k++) drive_cycle(1'b0, '0, 1'b1, 1'b0);
    checks++;
    if (valid_o !== 1'b0 || count_o !== '0) begin
      failures++; $display("FAIL wrap_end got valid=%b count=%0d exp valid=0 count=0", valid_o, count_o);
    end
    for (int i = 0; i < exp_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin failures++; $display("FAIL wrap_data[%0d] got=%0h exp=%0h", i, obs_q[i], exp_q[i]); end
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_simultaneous();
    for (int k = 0; k < DEPTH; k++) drive_cycle(1'b1, DATA_W'($urandom_range(0, 255)), 1'b0, 1'b0);
    checks++;
    if (ready_o !== 1'b0 || count_o !== CNT_W'(DEPTH)) begin
      failures++; $display("FAIL simul_full got ready=%b count=%0d exp ready=0 count=8", ready_o, count_o);
    end
    drive_cycle(1'b1, 8'hAA, 1'b1, 1'b0);
    checks++;
    if (count_o !== CNT_W'(7)) begin failures++; $display("FAIL simul_full_count got=%0d exp=7", count_o); end
    checks++;
    if (ready_o !== 1'b1) begin failures++; $display("FAIL simul_ready_next got=%b exp=1", ready_o); end
    repeat (4) drive_cycle(1'b0, '0, 1'b1, 1'b0);
    checks++;
    if (count_o !== CNT_W'(3)) begin failures++; $display("FAIL simul_drain3 got=%0d exp=3", count_o); end
    drive_cycle(1'b1, DATA_W'($urandom_range(0, 255)), 1'b1, 1'b0);
    checks++;
    if (count_o !== CNT_W'(3)) begin failures++; $display("FAIL simul_pp3 got=%0d exp=3", count_o); end
    repeat (3) drive_cycle(1'b0, '0, 1'b1, 1'b0);
    checks++;
    if (valid_o !== 1'b0) begin failures++; $display("FAIL simul_end_valid got=%b exp=0", valid_o); end
    for (int i = 0; i < exp_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin failures++; $display("FAIL simul_data[%0d] got=%0h exp=%0h", i, obs_q[i], exp_q[i]); end
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_flush();
    repeat (5) drive_cycle(1'b1, DATA_W'($urandom_range(0, 255)), 1'b0, 1'b0);
    checks++;
    if (count_o !== CNT_W'(5)) begin failures++; $display("FAIL flush_pre_count got=%0d exp=5", count_o); end
    drive_cycle(1'b1, 8'h55, 1'b0, 1'b1);
    checks++;
    if (count_o !== '0) begin failures++; $display("FAIL flush_count got=%0d exp=0", count_o); end
    checks++;
    if (valid_o !== 1'b0) begin failures++; $display("FAIL flush_valid got=%b exp=0", valid_o); end
    checks++;
    if (ready_o !== 1'b1) begin failures++; $display("FAIL flush_ready got=%b exp=1", ready_o); end
    checks++;
    if (almost_empty_o !== 1'b1) begin failures++; $display("FAIL flush_ae got=%b exp=1", almost_empty_o); end
    drive_cycle(1'b1, 8'h3C, 1'b0, 1'b0);
    drive_cycle(1'b0, '0, 1'b1, 1'b0);
    checks++;
    if (obs_q.size() != 1 || obs_q[0] !== 8'h3C) begin
      failures++; $display("FAIL flush_after_data got_len=%0d exp_len=1 exp=3c", obs_q.size());
    end
    checks++;
    if (count_o !== '0) begin failures++; $display("FAIL flush_after_count got=%0d exp=0", count_o); end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_async_reset();
    repeat (4) drive_cycle(1'b1, DATA_W'($urandom_range(0, 255)), 1'b0, 1'b0);
    checks++;
    if (count_o !== CNT_W'(4)) begin failures++; $display("FAIL areset_pre_count got=%0d exp=4", count_o); end
    valid_i = 1'b0;
    arst = 1'b1;
    #1;
    checks++;
    if (count_o !== '0) begin failures++; $display("FAIL areset_count got=%0d exp=0", count_o); end
    checks++;
    if (valid_o !== 1'b0) begin failures++; $display("FAIL areset_valid got=%b exp=0", valid_o); end
    checks++;
    if (ready_o !== 1'b0) begin failures++; $display("FAIL areset_ready got=%b exp=0", ready_o); end
    checks++;
    if (almost_empty_o !== 1'b1) begin failures++; $display("FAIL areset_ae got=%b exp=1", almost_empty_o); end
    model_q.delete();
    mdl_ready = 1'b0;
    @(posedge clk);
    #1;
    arst = 1'b0;
    #1;
    drive_cycle(1'b0, '0, 1'b0, 1'b0);
    checks++;
    if (ready_o !== 1'b1) begin failures++; $display("FAIL areset_release_ready got=%b exp=1", ready_o); end
  endtask

  task automatic test_random();
    logic exp_af, exp_ae, exp_valid;
    for (int n = 0; n < 300; n++) begin
      drive_cycle($urandom_range(0, 3) != 0, DATA_W'($urandom_range(0, 255)),
                  $urandom_range(0, 1) == 1, $urandom_range(0, 31) == 0);
      exp_af    = (model_q.size() >= AF_THRESH);
      exp_ae    = (model_q.size() <= AE_THRESH);
      exp_valid = (model_q.size() != 0);
      checks++;
      if (count_o !== CNT_W'(model_q.size())) begin failures++; $display("FAIL rand_count got=%0d exp=%0d cyc=%0d", count_o, model_q.size(), n); end
      checks++;
      if (valid_o !== exp_valid) begin failures++; $display("FAIL rand_valid got=%b exp=%b cyc=%0d", valid_o, exp_valid, n); end
      checks++;
      if (ready_o !== mdl_ready) begin failures++; $display("FAIL rand_ready got=%b exp=%b cyc=%0d", ready_o, mdl_ready, n); end
      checks++;
      if (almost_full_o !== exp_af || almost_empty_o !== exp_ae) begin
        failures++; $display("FAIL rand_flags got af=%b ae=%b exp af=%b ae=%b cyc=%0d", almost_full_o, almost_empty_o, exp_af, exp_ae, n);
      end
    end
    for (int k = 0; k < 2 * DEPTH && model_q.size() != 0; k++) drive_cycle(1'b0, '0, 1'b1, 1'b0);
    for (int i = 0; i < exp_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin failures++; $display("FAIL rand_data[%0d] got=%0h exp=%0h", i, obs_q[i], exp_q[i]); end
    end
    exp_q.delete(); obs_q.delete();
  endtask

  initial begin
    arst = 1'b1; flush_i = 1'b0; valid_i = 1'b0; ready_i = 1'b0; data_i = '0;
    @(posedge clk);
    #2;
    test_reset();
    test_fill_drain();
    test_wrap();
    test_simultaneous();
    test_flush();
    test_async_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
